// File: rtl/rect_mask_pkg.sv
// Shared definitions for the masked RECTANGLE S-box schedulers.
package rect_mask_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int STATE_W     = 64;
  localparam int NIB_DEFAULT = 16;
  localparam int LAT_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/mask_lat_tracker.sv
// Valid-bit delay line that mirrors the register depth of a masked core.
// It advances only on cycles where the core itself advances, so its output
// marks the cycles on which the core output carries a real nibble.
module mask_lat_tracker #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_din,
  output logic o_dout
);

  logic [LAT-1:0] r_pipe;

  // Shift the valid bit one stage per enabled cycle; hold during stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe <= '0;
    end else if (i_en) begin
      r_pipe[0] <= i_din;
      for (int i = 1; i < LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_dout = r_pipe[LAT-1];

endmodule

// File: rtl/masked_sbox_sched.sv
// Serialises a 3-share state through one shared masked S-box core, one nibble
// per enabled cycle, and reassembles the 3-share result. Each share keeps its
// own feed and result datapath; shares are never mixed here.
module masked_sbox_sched
  import rect_mask_pkg::*;
#(
  parameter int NIB = NIB_DEFAULT,
  parameter int LAT = LAT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NIBBLE_W*NIB-1:0]   s1_in,
  input  logic [NIBBLE_W*NIB-1:0]   s2_in,
  input  logic [NIBBLE_W*NIB-1:0]   s3_in,
  output logic [NIBBLE_W*NIB-1:0]   s1_out,
  output logic [NIBBLE_W*NIB-1:0]   s2_out,
  output logic [NIBBLE_W*NIB-1:0]   s3_out,
  output logic                      busy,
  output logic                      done,
  input  logic                      rnd_valid,
  output logic                      rnd_ready,
  output logic                      core_en,
  output logic [NIBBLE_W-1:0]       core_x1,
  output logic [NIBBLE_W-1:0]       core_x2,
  output logic [NIBBLE_W-1:0]       core_x3,
  input  logic [NIBBLE_W-1:0]       core_y1,
  input  logic [NIBBLE_W-1:0]       core_y2,
  input  logic [NIBBLE_W-1:0]       core_y3
);

  localparam int W  = NIBBLE_W * NIB;
  localparam int CW = $clog2(NIB + 1);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  sched_state_t  r_state;
  logic [W-1:0]  r_feed1, r_feed2, r_feed3;
  logic [W-1:0]  r_res1, r_res2, r_res3;
  logic [W-1:0]  r_out1, r_out2, r_out3;
  logic [CW-1:0] r_fcnt, r_ccnt;

  logic          w_busy, w_en, w_trackIn, w_trackOut, w_capture, w_lastCapture;
  logic [W-1:0]  w_res1Next, w_res2Next, w_res3Next;

  assign w_busy        = (r_state == FEED) || (r_state == DRAIN);
  assign w_en          = w_busy && rnd_valid;
  assign w_trackIn     = (r_state == FEED);
  assign w_capture     = w_en && w_trackOut;
  assign w_lastCapture = w_capture && (r_ccnt == LAST);

  // Core outputs enter at the top so nibble i ends at bits [4i+3:4i].
  assign w_res1Next = {core_y1, r_res1[W-1:NIBBLE_W]};
  assign w_res2Next = {core_y2, r_res2[W-1:NIBBLE_W]};
  assign w_res3Next = {core_y3, r_res3[W-1:NIBBLE_W]};

  mask_lat_tracker #(.LAT(LAT)) u_tracker (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_en),
    .i_din  (w_trackIn),
    .o_dout (w_trackOut)
  );

  // Sequencer: latch shares, feed nibbles, collect core results, publish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_feed1 <= '0;
      r_feed2 <= '0;
      r_feed3 <= '0;
      r_res1  <= '0;
      r_res2  <= '0;
      r_res3  <= '0;
      r_out1  <= '0;
      r_out2  <= '0;
      r_out3  <= '0;
      r_fcnt  <= '0;
      r_ccnt  <= '0;
    end else begin
      if (w_capture) begin
        r_res1 <= w_res1Next;
        r_res2 <= w_res2Next;
        r_res3 <= w_res3Next;
        r_ccnt <= r_ccnt + CW'(1);
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_feed1 <= s1_in;
            r_feed2 <= s2_in;
            r_feed3 <= s3_in;
            r_fcnt  <= '0;
            r_ccnt  <= '0;
            r_state <= FEED;
          end
        end
        FEED: begin
          if (w_en) begin
            r_feed1 <= r_feed1 >> NIBBLE_W;
            r_feed2 <= r_feed2 >> NIBBLE_W;
            r_feed3 <= r_feed3 >> NIBBLE_W;
            r_fcnt  <= r_fcnt + CW'(1);
            if (r_fcnt == LAST) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_lastCapture) begin
            r_out1  <= w_res1Next;
            r_out2  <= w_res2Next;
            r_out3  <= w_res3Next;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign s1_out    = r_out1;
  assign s2_out    = r_out2;
  assign s3_out    = r_out3;
  assign busy      = w_busy;
  assign done      = (r_state == DONE);
  assign core_en   = w_en;
  assign rnd_ready = w_en;
  assign core_x1   = (r_state == FEED) ? r_feed1[NIBBLE_W-1:0] : '0;
  assign core_x2   = (r_state == FEED) ? r_feed2[NIBBLE_W-1:0] : '0;
  assign core_x3   = (r_state == FEED) ? r_feed3[NIBBLE_W-1:0] : '0;

endmodule
